fres_trim_seq: RTL and testbench

- Clocked digital sequencer that drives the real-valued `rval` input of the EEnet resistor model (fres) in the CDR termination/trim path.
- Accepts a target trim code over a valid/ready handshake.
- Ramps the applied code one LSB at a time, with a programmable dwell between steps, so the downstream EEnet solver never sees large resistance jumps that cause iteration storms.
- Converts the current code to ohms: rval = RMIN + code*RSTEP.

---
 rtl/fres_trim_seq_pkg.sv | 24 ++
 rtl/fres_trim_seq.sv | 109 ++++++++++
 tb/tb_fres_trim_seq.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fres_trim_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fres_trim_seq_pkg
// Description : Shared types and code-to-ohms helper for the fres trim
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fres_trim_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        DWELL = 2'd2
    } fres_trim_state_t;

    // Linear trim law; the open-circuit override is applied by the caller.
    function automatic real trim2ohm(input int unsigned code,
                                     input real         rmin,
                                     input real         rstep);
        return rmin + real'(code) * rstep;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fres_trim_seq.sv
`default_nettype none
// ============================================================================
// Module      : fres_trim_seq
// Description : Ramps the fres trim code one LSB at a time toward a requested
//               target, with a programmable dwell between steps, and drives
//               the resistor value derived from the applied code.
//               Optional macro FRES_TRIM_SEQ_OPEN_EN maps code 0 to ROPEN.
// Revision    : 1.0 - initial release
// ============================================================================
module fres_trim_seq
    import fres_trim_seq_pkg::*;
#(
    parameter int unsigned CW       = 6,
    parameter real         RMIN     = 50.0,
    parameter real         RSTEP    = 5.0,
    parameter int unsigned DWELL    = 4,
    parameter int unsigned RST_CODE = 32,
    parameter real         ROPEN    = 1.0e15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] tgt_code,
    input  logic          tgt_valid,
    output logic          tgt_ready,
    input  logic          hold,
    output logic [CW-1:0] code,
    output real           rval,
    output logic          busy,
    output logic          settled
);

    localparam int unsigned CNT_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    fres_trim_state_t state_q, state_d;
    logic [CW-1:0]    code_q, code_d;
    logic [CW-1:0]    target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             settled_q, settled_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= CW'(RST_CODE);
            target_q  <= '0;
            cnt_q     <= '0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        settled_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Acceptance ignores hold so a request is never lost.
                if (tgt_valid) begin
                    target_d = tgt_code;
                    state_d  = STEP;
                end
            end
            STEP: begin
                if (!hold) begin
                    if (code_q == target_q) begin
                        state_d   = IDLE;
                        settled_d = 1'b1;
                    end else begin
                        code_d  = (code_q < target_q) ? code_q + 1'b1 : code_q - 1'b1;
                        cnt_d   = CNT_W'(DWELL);
                        state_d = (DWELL == 0) ? STEP : fres_trim_seq_pkg::DWELL;
                    end
                end
            end
            fres_trim_seq_pkg::DWELL: begin
                if (!hold) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_d == '0) begin
                        state_d = STEP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign settled   = settled_q;
    assign code      = code_q;

    // Derived only from the registered code, so rval moves on code edges only.
`ifdef FRES_TRIM_SEQ_OPEN_EN
    assign rval = (code_q == '0) ? ROPEN : trim2ohm(32'(code_q), RMIN, RSTEP);
`else
    logic unused_ropen;
    assign unused_ropen = (ROPEN >= RMIN);
    assign rval = trim2ohm(32'(code_q), RMIN, RSTEP);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fres_trim_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fres_trim_seq
// Description : Self-checking bench for fres_trim_seq (DWELL=4 and DWELL=0).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fres_trim_seq;

    localparam int  CW    = 6;
    localparam int  DW    = 4;
    localparam real RMIN  = 50.0;
    localparam real RSTEP = 5.0;
    localparam real ROPEN = 1.0e15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] tgt_code;
    logic          tgt_valid;
    logic          tgt_ready;
    logic          hold;
    logic [CW-1:0] code;
    real           rval;
    logic          busy;
    logic          settled;

    logic [CW-1:0] tgt_code1;
    logic          tgt_valid1;
    logic          tgt_ready1;
    logic          hold1;
    logic [CW-1:0] code1;
    real           rval1;
    logic          busy1;
    logic          settled1;

    always #5 clk = ~clk;

    fres_trim_seq #(.CW(CW), .RMIN(RMIN), .RSTEP(RSTEP), .DWELL(DW),
                    .RST_CODE(32), .ROPEN(ROPEN)) u_dut (
        .clk(clk), .rst_n(rst_n), .tgt_code(tgt_code), .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready), .hold(hold), .code(code), .rval(rval),
        .busy(busy), .settled(settled));

    fres_trim_seq #(.CW(CW), .RMIN(RMIN), .RSTEP(RSTEP), .DWELL(0),
                    .RST_CODE(32), .ROPEN(ROPEN)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_code(tgt_code1), .tgt_valid(tgt_valid1),
        .tgt_ready(tgt_ready1), .hold(hold1), .code(code1), .rval(rval1),
        .busy(busy1), .settled(settled1));

    int total = 0;
    int bad   = 0;

    // Reference model: progress is counted in non-hold edges since acceptance;
    // step i lands at progress 1+i*(DW+1), completion at 1+d*(DW+1).
    bit  m_idle;
    bit  m_settled;
    int  m_code, m_start, m_tgt, m_act;
    int  prev_code;
    real prev_rval;

    typedef struct {
        int tgt;
        int exp_code;
        int exp_lat;
    } vec_t;
    vec_t tbl[6];

    int  rec_code[0:20];
    bit  rec_set[0:20];

    function automatic real ohm(input int c);
`ifdef FRES_TRIM_SEQ_OPEN_EN
        if (c == 0) return ROPEN;
`endif
        return RMIN + real'(c) * RSTEP;
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkr(input string nm, input real got, input real exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %f expected %f at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle    = 1'b1;
        m_settled = 1'b0;
        m_code    = 32;
    endtask

    task automatic model_step(input bit v, input int tc, input bit h, input bit rn);
        int d, n;
        m_settled = 1'b0;
        if (!rn) begin
            model_reset();
        end else if (m_idle) begin
            if (v) begin
                m_idle  = 1'b0;
                m_start = m_code;
                m_tgt   = tc;
                m_act   = 0;
            end
        end else if (!h) begin
            m_act++;
            d = (m_tgt >= m_start) ? m_tgt - m_start : m_start - m_tgt;
            n = (m_act - 1) / (DW + 1) + 1;
            if (n > d) n = d;
            m_code = (m_tgt >= m_start) ? m_start + n : m_start - n;
            if (m_act == 1 + d * (DW + 1)) begin
                m_idle    = 1'b1;
                m_settled = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("code", code, m_code);
        chkr("rval", rval, ohm(m_code));
        chk("tgt_ready", tgt_ready, m_idle);
        chk("busy", busy, !m_idle);
        chk("settled", settled, m_settled);
        total++;
        if (int'(code) == prev_code && rval != prev_rval) begin
            bad++;
            $display("FAIL rval_without_code: got %f expected %f", rval, prev_rval);
        end
        prev_code = int'(code);
        prev_rval = rval;
    endtask

    task automatic tick();
        bit v, h, rn;
        int tc;
        v  = tgt_valid;
        h  = hold;
        rn = rst_n;
        tc = int'(tgt_code);
        @(posedge clk);
        #1;
        model_step(v, tc, h, rn);
        check_all();
    endtask

    task automatic run_req(input int tc, output int lat);
        tgt_valid = 1'b1;
        tgt_code  = CW'(tc);
        tick();
        tgt_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            lat++;
            if (settled) break;
        end
        if (!settled) begin
            total++;
            bad++;
            $display("FAIL settle_timeout: got no settled expected pulse (tgt %0d)", tc);
        end
    endtask

    initial begin
        int lat, nset;
        real r0;

        tbl[0] = '{tgt: 29, exp_code: 29, exp_lat: 1 + 6 * (DW + 1)};
        tbl[1] = '{tgt: 63, exp_code: 63, exp_lat: 1 + 34 * (DW + 1)};
        tbl[2] = '{tgt: 0,  exp_code: 0,  exp_lat: 1 + 63 * (DW + 1)};
        tbl[3] = '{tgt: 0,  exp_code: 0,  exp_lat: 1};
        tbl[4] = '{tgt: 1,  exp_code: 1,  exp_lat: 1 + 1 * (DW + 1)};
        tbl[5] = '{tgt: 32, exp_code: 32, exp_lat: 1 + 31 * (DW + 1)};

        rst_n      = 1'b0;
        tgt_code   = '0;
        tgt_valid  = 1'b0;
        hold       = 1'b0;
        tgt_code1  = '0;
        tgt_valid1 = 1'b0;
        hold1      = 1'b0;
        model_reset();
        prev_code  = 32;
        prev_rval  = 210.0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("reset_code", code, 32);
        chkr("reset_rval", rval, 210.0);
        chk("reset_ready", tgt_ready, 1);
        chk("reset_settled", settled, 0);

        // Ramp 32 -> 35, per-edge schedule
        tgt_valid = 1'b1;
        tgt_code  = 6'd35;
        tick();
        tgt_valid = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            rec_code[e] = int'(code);
            rec_set[e]  = settled;
        end
        chk("ramp_e1", rec_code[1], 33);
        chk("ramp_e5", rec_code[5], 33);
        chk("ramp_e6", rec_code[6], 34);
        chk("ramp_e11", rec_code[11], 35);
        chk("ramp_settled_e15", rec_set[15], 0);
        chk("ramp_settled_e16", rec_set[16], 1);
        chk("ramp_ready_e16", tgt_ready, 1);
        chkr("ramp_rval", rval, 225.0);

        // Zero-distance request
        r0 = rval;
        run_req(35, lat);
        chk("zero_lat", lat, 1);
        chkr("zero_rval", rval, r0);

        // Table of requests with settle latency
        foreach (tbl[i]) begin
            run_req(tbl[i].tgt, lat);
            chk("tbl_lat", lat, tbl[i].exp_lat);
            chk("tbl_code", code, tbl[i].exp_code);
        end

        // Hold during first dwell, with a busy-time request for 40
        tgt_valid = 1'b1;
        tgt_code  = 6'd29;
        tick();
        for (int e = 1; e <= 19; e++) begin
            hold      = (e >= 2 && e <= 4);
            tgt_valid = (e >= 2 && e <= 12);
            tgt_code  = 6'd40;
            tick();
            rec_code[e] = int'(code);
            rec_set[e]  = settled;
        end
        hold      = 1'b0;
        tgt_valid = 1'b0;
        chk("hold_e1", rec_code[1], 31);
        chk("hold_e8", rec_code[8], 31);
        chk("hold_e9", rec_code[9], 30);
        chk("hold_e13", rec_code[13], 30);
        chk("hold_e14", rec_code[14], 29);
        chk("hold_settled_e18", rec_set[18], 0);
        chk("hold_settled_e19", rec_set[19], 1);

        // Reset mid-ramp at code 30
        tgt_valid = 1'b1;
        tgt_code  = 6'd35;
        tick();
        tgt_valid = 1'b0;
        repeat (3) tick();
        chk("mid_code", code, 30);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_code", code, 32);
        chkr("rst_rval", rval, 210.0);
        tick();
        #1;
        rst_n = 1'b1;
        nset = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (settled) nset++;
        end
        chk("rst_no_settled", nset, 0);
        run_req(33, lat);
        chk("post_rst_lat", lat, 1 + DW + 1);
        chk("post_rst_code", code, 33);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            hold      = ($urandom_range(0, 3) == 0);
            tgt_valid = m_idle ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            tgt_code  = CW'($urandom_range(0, 63));
            tick();
        end
        hold      = 1'b0;
        tgt_valid = 1'b0;
        for (int c = 0; c < 400 && !m_idle; c++) tick();

        // DWELL=0 instance: 32 -> 2, then 2 -> 0
        tgt_valid1 = 1'b1;
        tgt_code1  = 6'd2;
        tick();
        tgt_valid1 = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (settled1) break;
        end
        chk("d0_lat", lat, 31);
        chk("d0_code", code1, 2);
        chkr("d0_rval2", rval1, 60.0);
        tgt_valid1 = 1'b1;
        tgt_code1  = 6'd0;
        tick();
        tgt_valid1 = 1'b0;
        chkr("d0_accept_rval", rval1, 60.0);
        tick();
        chkr("d0_rval1", rval1, 55.0);
        tick();
        chkr("d0_rval0", rval1, ohm(0));
        chk("d0_code0", code1, 0);
        chk("d0_settled_early", settled1, 0);
        tick();
        chk("d0_settled", settled1, 1);
        chk("d0_ready", tgt_ready1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
